// File: rtl/lut_config_loader.sv
// Configuration-side feeder for the memory LUT.
// Collects a framed stream of cfg words into one image and commits it to the LUT with a single cen pulse.
module lut_config_loader #(
    parameter int unsigned INPUTS       = 4,
    parameter int unsigned MEM_SIZE     = 2 ** INPUTS,
    parameter int unsigned CONFIG_WIDTH = 4
) (
    input  logic                    cclk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic                    cen,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WORDS = MEM_SIZE / CONFIG_WIDTH;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    // Reject parameter sets that cannot form a whole number of words.
    if (INPUTS == 0 || CONFIG_WIDTH == 0 || (MEM_SIZE % CONFIG_WIDTH) != 0 || WORDS == 0) begin : g_param_check
        $error("lut_config_loader: MEM_SIZE must be a non-zero multiple of CONFIG_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MEM_SIZE-1:0]   image_q, image_d;
    logic                  ready_q, ready_d;
    logic                  cen_q, cen_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  xfer_c;
    int unsigned           base_c;

    // State and registered outputs.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            image_q <= '0;
            ready_q <= 1'b0;
            cen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            image_q <= image_d;
            ready_q <= ready_d;
            cen_q   <= cen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        image_d = image_q;
        done_d  = done_q;
        xfer_c  = cfg_valid && ready_q;
        base_c  = 32'(cnt_q) * CONFIG_WIDTH;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (xfer_c) begin
                    image_d[base_c +: CONFIG_WIDTH] = cfg_data;
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_COMMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_LOAD);
        cen_d   = (state_d == S_COMMIT);
        busy_d  = (state_d == S_LOAD) || (state_d == S_COMMIT);
    end

    assign cfg_ready  = ready_q;
    assign config_out = image_q;
    assign cen        = cen_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: 16-bit image with 4-bit words, plus a 1-bit-word instance.
module tb_lut_config_loader;

    logic        cclk = 1'b0;
    logic        rst_n;
    logic        start, cfg_valid, cfg_ready, cen, busy, done;
    logic [3:0]  cfg_data;
    logic [15:0] config_out;

    logic        start1, cfg_valid1, cfg_ready1, cen1, busy1, done1;
    logic [0:0]  cfg_data1;
    logic [15:0] config_out1;

    int n_checks = 0;
    int n_fail   = 0;
    int cen_count = 0;
    int xfer_count = 0;

    always #5 cclk = ~cclk;

    lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) u_dut (
        .cclk(cclk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .config_out(config_out), .cen(cen), .busy(busy), .done(done)
    );

    lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(1)) u_dut1 (
        .cclk(cclk), .rst_n(rst_n), .start(start1), .cfg_data(cfg_data1), .cfg_valid(cfg_valid1),
        .cfg_ready(cfg_ready1), .config_out(config_out1), .cen(cen1), .busy(busy1), .done(done1)
    );

    always @(negedge cclk) if (cen === 1'b1) cen_count++;
    always @(posedge cclk) if (rst_n === 1'b1 && cfg_valid === 1'b1 && cfg_ready === 1'b1) xfer_count++;

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // Feeds four words; optionally stalls before word gap_at and pokes start alongside word 1.
    task automatic send_words(input logic [15:0] w, input int gap_at, input int gap_len, input bit poke_start);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                cfg_valid = 1'b0;
                cfg_data  = 4'hF;
                repeat (gap_len) tick();
            end
            start     = poke_start && (k == 1);
            cfg_valid = 1'b1;
            cfg_data  = w[k*4 +: 4];
            tick();
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (config_out !== 16'h0) begin n_fail++; $display("FAIL reset_config_out: got %h expected 0000", config_out); end
        n_checks++; if (cen !== 1'b0)        begin n_fail++; $display("FAIL reset_cen: got %b expected 0", cen); end
        n_checks++; if (cfg_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (config_out1 !== 16'h0 || cfg_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: got %h/%b expected 0000/0", config_out1, cfg_ready1); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_noise();
        int x0 = xfer_count;
        cfg_valid = 1'b1;
        cfg_data  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL idle_cfg_ready[%0d]: got %b expected 0", i, cfg_ready); end
            n_checks++; if (config_out !== 16'h0) begin n_fail++; $display("FAIL idle_config_out[%0d]: got %h expected 0000", i, config_out); end
        end
        cfg_valid = 1'b0;
        n_checks++; if (xfer_count != x0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_xfer: got %0d xfers busy %b expected 0 xfers busy 0", xfer_count - x0, busy); end
    endtask

    task automatic test_basic();
        int c0 = cen_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (cfg_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_load_entry: got ready %b busy %b expected 1 1", cfg_ready, busy); end
        send_words(16'h4321, -1, 0, 1'b0);
        n_checks++; if (cen !== 1'b1) begin n_fail++; $display("FAIL basic_cen_commit: got %b expected 1", cen); end
        n_checks++; if (config_out !== 16'h4321) begin n_fail++; $display("FAIL basic_config_out: got %h expected 4321", config_out); end
        n_checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL basic_commit_flags: got busy %b ready %b expected 1 0", busy, cfg_ready); end
        tick();
        n_checks++; if (cen !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got cen %b done %b busy %b expected 0 1 0", cen, done, busy); end
        tick();
        n_checks++; if (cen_count - c0 != 1) begin n_fail++; $display("FAIL basic_cen_pulses: got %0d expected 1", cen_count - c0); end
    endtask

    task automatic test_valid_gaps();
        int c0 = cen_count;
        int x0 = xfer_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(16'h4321, 2, 3, 1'b0);
        n_checks++; if (cen !== 1'b1 || config_out !== 16'h4321) begin n_fail++; $display("FAIL gaps_commit: got cen %b image %h expected 1 4321", cen, config_out); end
        tick();
        tick();
        n_checks++; if (cen_count - c0 != 1) begin n_fail++; $display("FAIL gaps_cen_pulses: got %0d expected 1", cen_count - c0); end
        n_checks++; if (xfer_count - x0 != 4) begin n_fail++; $display("FAIL gaps_xfers: got %0d expected 4", xfer_count - x0); end
    endtask

    task automatic test_start_in_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(16'h8765, -1, 0, 1'b1);
        n_checks++; if (cen !== 1'b1 || config_out !== 16'h8765) begin n_fail++; $display("FAIL start_in_load: got cen %b image %h expected 1 8765", cen, config_out); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        int c0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b1; cfg_data = 4'hA; tick();
        cfg_data = 4'hB; tick();
        cfg_valid = 1'b0;
        n_checks++; if (config_out !== 16'h87BA) begin n_fail++; $display("FAIL partial_hold: got %h expected 87ba", config_out); end
        c0 = cen_count;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (config_out !== 16'h0 || busy !== 1'b0 || cfg_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midload_reset: got image %h busy %b ready %b done %b expected 0000 0 0 0", config_out, busy, cfg_ready, done); end
        cfg_valid = 1'b1; cfg_data = 4'hC;
        repeat (3) tick();
        cfg_valid = 1'b0;
        n_checks++; if (cen_count != c0 || config_out !== 16'h0) begin n_fail++; $display("FAIL midload_no_commit: got %0d pulses image %h expected 0 0000", cen_count - c0, config_out); end
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(16'hDCBA, -1, 0, 1'b0);
        n_checks++; if (cen !== 1'b1 || config_out !== 16'hDCBA) begin n_fail++; $display("FAIL fresh_frame: got cen %b image %h expected 1 dcba", cen, config_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int c0 = cen_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(16'h4321, -1, 0, 1'b0);
        tick();
        n_checks++; if (done !== 1'b1 || config_out !== 16'h4321) begin n_fail++; $display("FAIL b2b_first: got done %b image %h expected 1 4321", done, config_out); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got done %b busy %b ready %b expected 0 1 1", done, busy, cfg_ready); end
        send_words(16'h8765, -1, 0, 1'b0);
        n_checks++; if (cen !== 1'b1 || config_out !== 16'h8765) begin n_fail++; $display("FAIL b2b_second: got cen %b image %h expected 1 8765", cen, config_out); end
        tick();
        tick();
        n_checks++; if (cen_count - c0 != 2) begin n_fail++; $display("FAIL b2b_cen_pulses: got %0d expected 2", cen_count - c0); end
    endtask

    task automatic test_width1_sweep();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cfg_valid1 = 1'b1;
            cfg_data1  = 1'(k % 2);
            tick();
            if (k == 14) begin
                n_checks++; if (cen1 !== 1'b0) begin n_fail++; $display("FAIL w1_early_cen: got %b expected 0", cen1); end
            end
        end
        cfg_valid1 = 1'b0;
        n_checks++; if (cen1 !== 1'b1) begin n_fail++; $display("FAIL w1_cen: got %b expected 1", cen1); end
        n_checks++; if (config_out1 !== 16'hAAAA) begin n_fail++; $display("FAIL w1_config_out: got %h expected aaaa", config_out1); end
        tick();
        n_checks++; if (cen1 !== 1'b0 || done1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL w1_done: got cen %b done %b busy %b expected 0 1 0", cen1, done1, busy1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = 4'h0;
        start1 = 1'b0; cfg_valid1 = 1'b0; cfg_data1 = 1'b0;
        test_reset();
        test_idle_noise();
        test_basic();
        test_valid_gaps();
        test_start_in_load();
        test_reset_mid_load();
        test_back_to_back();
        test_width1_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
